spi_request_arbiter: RTL and testbench
======================================

Name: spi_request_arbiter

Overview:
- Round-robin arbiter and transaction sequencer that shares one SPI master between NUM_REQ requesters.
- Accepts per-requester byte transfer requests (target slave + byte) and drives the master's start/slaveSelect/masterDataToSend.
- Tracks master chip-select activity to detect transfer completion, then returns the received byte with a completion or error pulse.
- Sits between client logic and the SPI master; the only agent that asserts the master's start.

Parameters:
NUM_REQ, 3, number of requesters (1..8)
START_CYCLES, 2, clk cycles start is held high per transfer (>=1)
TIMEOUT, 64, max clk cycles waiting in WAIT_BUSY or WAIT_DONE before error (>=4)

Ports:
clk  in  1  system clock, all logic on posedge
reset  in  1  asynchronous, active-high reset
req  in  NUM_REQ  per-requester request level; held until ack or err
req_slave  in  2*NUM_REQ  slave index per requester, bits [2k+1:2k]
req_data  in  8*NUM_REQ  byte to send per requester, bits [8k+7:8k]
ack  out  NUM_REQ  one-cycle completion pulse to granted requester
err  out  NUM_REQ  one-cycle timeout pulse to granted requester
rx_data  out  8  byte received on last completed transfer
busy  out  1  high whenever state != IDLE
start  out  1  to master start
slaveSelect  out  2  to master slaveSelect
masterDataToSend  out  8  to master data input
CS  in  3  master chip-select, 3'b111 = idle
masterDataReceived  in  8  master received byte

Behaviour:
- Reset (async, any state): state=IDLE, rr pointer=0, start=0, slaveSelect=0, masterDataToSend=0, ack=0, err=0, rx_data=0, busy=0, counters=0. Reset mid-transfer abandons it; no ack/err is issued.
- States: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, COMPLETE.
- IDLE: if any req bit is set, grant the first set bit searching upward from rr pointer with wrap. Latch grant index g, slaveSelect=req_slave[g], masterDataToSend=req_data[g]. Next state LAUNCH. Arbitration is the same cycle req is seen.
- LAUNCH: start=1 for exactly START_CYCLES cycles, then start=0 and go to WAIT_BUSY. slaveSelect and data are held stable from LAUNCH through COMPLETE.
- WAIT_BUSY: wait for CS != 3'b111, then go to WAIT_DONE. If TIMEOUT cycles pass first, go to COMPLETE with error.
- WAIT_DONE: wait for CS == 3'b111, then go to COMPLETE. The timeout counter restarts on entry; on expiry, go to COMPLETE with error.
- COMPLETE (1 cycle), success: rx_data<=masterDataReceived, ack[g]=1.
- COMPLETE (1 cycle), error: rx_data unchanged, err[g]=1.
- COMPLETE, both cases: rr pointer<=(g+1) mod NUM_REQ, then return to IDLE.
- ack and err are mutually exclusive, one-hot, and only ever asserted in COMPLETE.
- Request changes: req dropping after grant does not abort the transfer. req_slave/req_data changes after grant are ignored.
- Requester re-request: one that re-asserts in the COMPLETE cycle is seen in the following IDLE cycle, still subject to round-robin.
- Throughput: minimum back-to-back spacing is 1 IDLE cycle between COMPLETE and the next LAUNCH.
- Slave index 3 (invalid for the master): still launched. Expected to time out in WAIT_BUSY -> err.
- CS glitching to 111 for 1 cycle in WAIT_DONE is treated as completion; no filtering.

Test Plan:
- Single request: req=3'b001, slave=1, data=8'hA5; model master returns 8'h3C -> start high 2 cycles; slaveSelect=1; ack[0] pulse once; rx_data=8'h3C; busy low one cycle after COMPLETE.
- Contention: req=3'b111 held for three transfers -> grant order 0,1,2; three ack pulses, one per requester, in that order; rr pointer back to 0.
- Fairness: requester 0 re-requests immediately after each ack while requester 2 holds req -> order 0,1(if requesting),2,0; requester 2 is never starved beyond NUM_REQ-1 transfers.
- Busy timeout: CS held 3'b111 after start -> err[g] pulses exactly TIMEOUT+START_CYCLES+1 cycles after grant; no ack; rx_data unchanged.
- Done timeout: CS held 3'b110 permanently -> err pulse after TIMEOUT cycles in WAIT_DONE.
- Reset mid-WAIT_DONE: assert reset asynchronously -> all outputs zero immediately, no ack/err; a new request after release is served normally.

Source files
------------

// File: rtl/spi_request_arbiter.sv
// Round-robin arbiter that shares one SPI master between NUM_REQ requesters,
// sequencing start/slaveSelect/data and reporting completion or timeout per requester.
module spi_request_arbiter #(
  parameter int NUM_REQ      = 3,
  parameter int START_CYCLES = 2,
  parameter int TIMEOUT      = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [2*NUM_REQ-1:0]   req_slave,
  input  logic [8*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]     ack,
  output logic [NUM_REQ-1:0]     err,
  output logic [7:0]             rx_data,
  output logic                   busy,
  output logic                   start,
  output logic [1:0]             slaveSelect,
  output logic [7:0]             masterDataToSend,
  input  logic [2:0]             CS,
  input  logic [7:0]             masterDataReceived
);

  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int SUM_W   = IDX_W + 1;
  localparam int CNT_MAX = (TIMEOUT > START_CYCLES) ? TIMEOUT : START_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, COMPLETE} state_t;

  state_t            state;
  logic [IDX_W-1:0]  rr;
  logic [IDX_W-1:0]  g;
  logic [IDX_W-1:0]  pick;
  logic              found;
  logic [SUM_W-1:0]  cand;
  logic [CNT_W-1:0]  cnt;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    return NUM_REQ'(1) << idx;
  endfunction

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx);
    if (idx == IDX_W'(NUM_REQ - 1)) return '0;
    return idx + IDX_W'(1);
  endfunction

  // First requesting index at or above the rr pointer, wrapping around.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, rr} + SUM_W'(i);
      if (cand >= SUM_W'(NUM_REQ)) cand = cand - SUM_W'(NUM_REQ);
      if (!found && req[cand[IDX_W-1:0]]) begin
        found = 1'b1;
        pick  = cand[IDX_W-1:0];
      end
    end
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      rr               <= '0;
      g                <= '0;
      cnt              <= '0;
      start            <= 1'b0;
      slaveSelect      <= '0;
      masterDataToSend <= '0;
      ack              <= '0;
      err              <= '0;
      rx_data          <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            g                <= pick;
            slaveSelect      <= req_slave[{pick, 1'b0} +: 2];
            masterDataToSend <= req_data[{pick, 3'b000} +: 8];
            start            <= 1'b1;
            cnt              <= '0;
            state            <= LAUNCH;
          end
        end
        LAUNCH: begin
          if (cnt == CNT_W'(START_CYCLES - 1)) begin
            start <= 1'b0;
            cnt   <= '0;
            state <= WAIT_BUSY;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        WAIT_BUSY: begin
          if (CS != 3'b111) begin
            cnt   <= '0;
            state <= WAIT_DONE;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            err   <= onehot(g);
            cnt   <= '0;
            state <= COMPLETE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        WAIT_DONE: begin
          // A single idle CS cycle counts as completion; no deglitching.
          if (CS == 3'b111) begin
            ack     <= onehot(g);
            rx_data <= masterDataReceived;
            cnt     <= '0;
            state   <= COMPLETE;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            err   <= onehot(g);
            cnt   <= '0;
            state <= COMPLETE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        COMPLETE: begin
          ack   <= '0;
          err   <= '0;
          rr    <= wrap_inc(g);
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_request_arbiter.sv
// Bench for spi_request_arbiter: behavioural SPI master, random requesters and
// a round-robin reference model, checked with immediate assertions.
module tb_spi_request_arbiter;
  localparam int N  = 3;
  localparam int SC = 2;
  localparam int T  = 64;

  logic             clk = 1'b0;
  logic             reset;
  logic [N-1:0]     req;
  logic [2*N-1:0]   req_slave;
  logic [8*N-1:0]   req_data;
  logic [N-1:0]     ack, err;
  logic [7:0]       rx_data;
  logic             busy, start;
  logic [1:0]       slaveSelect;
  logic [7:0]       masterDataToSend;
  logic [2:0]       CS;
  logic [7:0]       masterDataReceived;

  spi_request_arbiter #(.NUM_REQ(N), .START_CYCLES(SC), .TIMEOUT(T)) dut (
    .clk(clk), .reset(reset), .req(req), .req_slave(req_slave), .req_data(req_data),
    .ack(ack), .err(err), .rx_data(rx_data), .busy(busy), .start(start),
    .slaveSelect(slaveSelect), .masterDataToSend(masterDataToSend),
    .CS(CS), .masterDataReceived(masterDataReceived)
  );

  always #5 clk = ~clk;

  // SPI master model: mode 0 normal, mode 2 holds CS active forever once selected.
  int         m_mode = 0;
  int         m_phase;
  int         m_cnt;
  logic       start_q;
  logic [1:0] m_sel;
  logic [7:0] m_byte;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      CS <= 3'b111; masterDataReceived <= 8'h00; m_phase <= 0; m_cnt <= 0;
      start_q <= 1'b0; m_sel <= 2'd0; m_byte <= 8'h00;
    end else begin
      start_q <= start;
      case (m_phase)
        0: if (start && !start_q && slaveSelect != 2'd3) begin
             m_sel <= slaveSelect; m_byte <= masterDataToSend ^ 8'h99;
             m_cnt <= $urandom_range(1, 3); m_phase <= 1;
           end
        1: if (m_cnt == 0) begin
             CS <= ~(3'b001 << m_sel); m_cnt <= $urandom_range(2, 8); m_phase <= 2;
           end else m_cnt <= m_cnt - 1;
        default: if (m_mode != 2) begin
             if (m_cnt == 0) begin
               CS <= 3'b111; masterDataReceived <= m_byte; m_phase <= 0;
             end else m_cnt <= m_cnt - 1;
           end
      endcase
    end
  end

  int         n_checks = 0;
  int         n_fail = 0;
  logic [N-1:0] pending;
  logic [1:0] rq_slave [N];
  logic [7:0] rq_data  [N];
  int         rr_m = 0;
  logic [7:0] rx_m = 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] onehot(input int k);
    return N'(1) << k;
  endfunction

  function automatic int arb(input logic [N-1:0] p, input int rr);
    for (int k = 0; k < N; k++) if (p[(rr + k) % N]) return (rr + k) % N;
    return 0;
  endfunction

  task automatic drive();
    req = pending;
    for (int k = 0; k < N; k++) begin
      req_slave[2*k +: 2] = rq_slave[k];
      req_data[8*k +: 8]  = rq_data[k];
    end
  endtask

  task automatic new_req(input int k, input bit allow_bad);
    pending[k] = 1'b1;
    rq_data[k] = 8'($urandom);
    rq_slave[k] = (allow_bad && $urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
  endtask

  // One arbitration round: waits for the pulse, checks it against the model,
  // applies the granted requester's re-request choice, then checks the idle cycle.
  task automatic serve(input logic [N-1:0] rereq, input bit perturb, input bit allow_bad,
                       output int c, output int cs_at, output int g,
                       output logic [N-1:0] pa, output logic [N-1:0] pe);
    int eg, starts;
    logic [1:0] es;
    logic [7:0] ed;
    bit e_err, got;
    eg = arb(pending, rr_m);
    g = eg;
    es = rq_slave[eg];
    ed = rq_data[eg];
    e_err = (es == 2'd3) || (m_mode == 2);
    c = 0; cs_at = 0; starts = 0; got = 0; pa = '0; pe = '0;
    while (!got && c < 400) begin
      @(negedge clk);
      c++;
      if (start) starts++;
      if (cs_at == 0 && CS != 3'b111) cs_at = c;
      if (perturb && c == 4) begin
        pending[eg] = 1'b0; rq_data[eg] = ~ed; rq_slave[eg] = es + 2'd1; drive();
      end
      if ((ack | err) != '0) got = 1;
    end
    pa = ack; pe = err;
    check("pulse_seen", 32'(got), 1);
    check("start_cycles", starts, SC);
    check("ack", ack, e_err ? '0 : onehot(eg));
    check("err", err, e_err ? onehot(eg) : '0);
    if (!e_err) rx_m = ed ^ 8'h99;
    check("rx_data", rx_data, rx_m);
    check("slave_sel", slaveSelect, es);
    check("tx_data", masterDataToSend, ed);
    check("busy_complete", busy, 1);
    rr_m = (eg + 1) % N;
    pending[eg] = 1'b0;
    if (rereq[eg]) new_req(eg, allow_bad);
    drive();
    @(negedge clk);
    check("pulse_width", {ack, err}, 0);
    check("busy_idle", busy, 0);
  endtask

  initial begin
    int c, cs_at, g, wait2;
    logic [N-1:0] pa, pe;
    logic [7:0] rx_before;

    reset = 1'b1;
    pending = '0;
    for (int k = 0; k < N; k++) begin rq_slave[k] = 2'd0; rq_data[k] = 8'h00; end
    drive();
    repeat (3) @(negedge clk);
    check("reset_state", {start, busy, ack, err, rx_data, slaveSelect, masterDataToSend}, 0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_after_reset", {start, busy, ack, err}, 0);

    // Contention: all three held, grant order 0,1,2 then back to 0.
    for (int k = 0; k < N; k++) begin new_req(k, 0); rq_slave[k] = 2'(k); end
    drive();
    for (int i = 0; i < 4; i++) begin
      serve((i < 3) ? '1 : '0, 0, 0, c, cs_at, g, pa, pe);
      check("rr_order", pa, onehot(i % 3));
    end
    pending = '0; drive();

    // Single request with the reference byte pair.
    pending[0] = 1'b1; rq_slave[0] = 2'd1; rq_data[0] = 8'hA5; drive();
    serve('0, 0, 0, c, cs_at, g, pa, pe);
    check("single_ack", pa, 3'b001);
    check("single_rx", rx_data, 8'h3C);

    // Fairness: requesters 0 and 2 always re-request, 1 joins at random.
    new_req(0, 0); new_req(2, 0); drive();
    wait2 = 0;
    for (int i = 0; i < 9; i++) begin
      serve(3'b101, 0, 0, c, cs_at, g, pa, pe);
      if (g == 2) begin
        check("no_starve", 32'(wait2 <= N - 1), 1);
        wait2 = 0;
      end else wait2++;
      if (!pending[1] && $urandom_range(0, 1) == 1) new_req(1, 0);
      drive();
    end

    // Random traffic, including invalid slave 3 and post-grant request changes.
    for (int i = 0; i < 16; i++) begin
      if (pending == '0) new_req($urandom_range(0, N - 1), 1);
      drive();
      serve(N'($urandom), 1'($urandom_range(0, 1)), 1, c, cs_at, g, pa, pe);
      for (int k = 0; k < N; k++)
        if (!pending[k] && $urandom_range(0, 3) == 0) new_req(k, 1);
      drive();
    end

    // Busy timeout: slave 3 never answers.
    pending = '0; new_req(1, 0); rq_slave[1] = 2'd3; drive();
    rx_before = rx_m;
    serve('0, 0, 0, c, cs_at, g, pa, pe);
    check("busy_timeout_cycles", c, T + SC + 1);
    check("busy_timeout_err", pe, 3'b010);
    check("busy_rx_held", rx_data, rx_before);

    // Done timeout: CS stays active.
    m_mode = 2; new_req(0, 0); drive();
    serve('0, 0, 0, c, cs_at, g, pa, pe);
    check("done_timeout_cycles", c - cs_at, T + 1);
    check("done_timeout_err", pe, 3'b001);
    m_mode = 0;
    for (int i = 0; i < 20 && CS != 3'b111; i++) @(negedge clk);
    check("cs_release", CS, 3'b111);

    // Reset in the middle of WAIT_DONE, then normal service.
    m_mode = 2; new_req(1, 0); drive();
    for (int i = 0; i < 20 && CS == 3'b111; i++) @(negedge clk);
    check("cs_active", 32'(CS != 3'b111), 1);
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1 check("reset_async", {start, busy, ack, err, rx_data, slaveSelect, masterDataToSend}, 0);
    repeat (2) begin
      @(negedge clk);
      check("reset_no_pulse", {ack, err}, 0);
    end
    m_mode = 0; rr_m = 0; rx_m = 8'h00;
    reset = 1'b0;
    serve('0, 0, 0, c, cs_at, g, pa, pe);
    check("post_reset_ack", pa, 3'b010);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
